// File: rtl/jtsdram_bank_resp_pkg.sv
// Shared definitions for the SDRAM bank responder: FSM encoding, bank count
// and default timing constants.
package jtsdram_pkg;

    localparam int NBANK              = 4;
    localparam int DEF_LAT            = 3;
    localparam int DEF_BURST          = 2;
    localparam int DEF_REF_PERIOD     = 384;
    localparam int DEF_REF_CYCLES     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REF   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WDONE = 3'd4
    } state_e;

    function automatic logic [3:0] bank_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/jtsdram_rr_arb.sv
// Four-way round-robin arbiter: the first requester at or after ptr wins.
module jtsdram_rr_arb (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand_s;

    // Scan from the farthest candidate back to ptr so the nearest requester is kept last.
    always_comb begin
        grant  = 4'b0000;
        idx    = 2'd0;
        any    = 1'b0;
        cand_s = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand_s = ptr + 2'(i);
            if (req[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
            end
        end
        if (any) begin
            grant = 4'b0001 << idx;
        end else begin
            grant = 4'b0000;
        end
    end

endmodule

// File: rtl/jtsdram_bank_resp.sv
// Four-bank SDRAM responder: round-robin request arbitration, fixed-latency
// bursts from inline word arrays, and periodic refresh windows.
module jtsdram_bank_resp
    import jtsdram_pkg::*;
#(
    parameter int AW         = 10,
    parameter int LAT        = DEF_LAT,
    parameter int BURST      = DEF_BURST,
    parameter int REF_PERIOD = DEF_REF_PERIOD,
    parameter int REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ba_rd,
    input  logic        ba_wr,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [15:0] ba0_din,
    input  logic [1:0]  ba0_din_m,
    input  logic        refresh_en,
    output logic [3:0]  ba_ack,
    output logic [3:0]  ba_dst,
    output logic [3:0]  ba_dok,
    output logic [3:0]  ba_rdy,
    output logic [15:0] data_read
);

    localparam int RW = $clog2(REF_PERIOD);
    localparam int CW = $clog2((REF_CYCLES > 16) ? REF_CYCLES : 16);

    state_e          state_r;
    logic [1:0]      ptr_r;
    logic [1:0]      bank_r;
    logic [1:0]      wcnt_r;
    logic [AW-1:0]   addr_r;
    logic            wr_r;
    logic [15:0]     din_r;
    logic [1:0]      mask_r;
    logic [CW-1:0]   cnt_r;
    logic [RW-1:0]   ref_cnt_r;
    logic            ref_pend_r;
    logic [15:0]     mem0_r [0:(1<<AW)-1];

    logic [3:0]      req_s;
    logic [3:0]      grant_s;
    logic [1:0]      gidx_s;
    logic            any_s;
    logic [AW-1:0]   addr_sel_s;
    logic [1:0]      rd_idx_s;
    logic [AW-1:0]   rd_addr_s;
    logic [15:0]     rd_data_s;
    logic [3:0]      bank_oh_s;
    logic            ref_wrap_s;
    logic            unused_s;

    assign req_s      = {ba_rd[3:1], ba_rd[0] | ba_wr};
    assign bank_oh_s  = bank_onehot(bank_r);
    assign ref_wrap_s = (ref_cnt_r == RW'(REF_PERIOD - 1));
    assign unused_s   = ^{ba0_addr[21:AW], ba1_addr[21:AW], ba2_addr[21:AW], ba3_addr[21:AW]};

    jtsdram_rr_arb u_arb (
        .req   (req_s),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (any_s)
    );

    // Address of the bank being granted this cycle.
    always_comb begin
        addr_sel_s = '0;
        case (gidx_s)
            2'd0:    addr_sel_s = ba0_addr[AW-1:0];
            2'd1:    addr_sel_s = ba1_addr[AW-1:0];
            2'd2:    addr_sel_s = ba2_addr[AW-1:0];
            2'd3:    addr_sel_s = ba3_addr[AW-1:0];
            default: addr_sel_s = '0;
        endcase
    end

    // Word about to be emitted; only bank 0 holds writable storage.
    always_comb begin
        rd_idx_s  = 2'd0;
        rd_data_s = 16'h0000;
        if (state_r == ST_DATA) begin
            rd_idx_s = wcnt_r + 2'd1;
        end else begin
            rd_idx_s = 2'd0;
        end
        rd_addr_s = addr_r + AW'(rd_idx_s);
        if (bank_r == 2'd0) begin
            rd_data_s = mem0_r[rd_addr_s];
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // Bank-0 array, written during the ack cycle with the latched byte mask.
    always_ff @(posedge clk) begin
        if (state_r == ST_WAIT && wr_r) begin
            if (!mask_r[1]) mem0_r[addr_r][15:8] <= din_r[15:8];
            if (!mask_r[0]) mem0_r[addr_r][7:0]  <= din_r[7:0];
        end
    end

    // Refresh timer; a wrap inside a refresh window is absorbed by the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_r  <= '0;
            ref_pend_r <= 1'b0;
        end else begin
            ref_cnt_r <= ref_wrap_s ? '0 : ref_cnt_r + RW'(1);
            if (!refresh_en || state_r == ST_REF) begin
                ref_pend_r <= 1'b0;
            end else if (ref_wrap_s) begin
                ref_pend_r <= 1'b1;
            end
        end
    end

    // Main FSM; output pulses are registered one cycle ahead of their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 2'd0;
            bank_r    <= 2'd0;
            wcnt_r    <= 2'd0;
            addr_r    <= '0;
            wr_r      <= 1'b0;
            din_r     <= 16'h0000;
            mask_r    <= 2'b00;
            cnt_r     <= '0;
            ba_ack    <= 4'b0000;
            ba_dst    <= 4'b0000;
            ba_dok    <= 4'b0000;
            ba_rdy    <= 4'b0000;
            data_read <= 16'h0000;
        end else begin
            ba_ack <= 4'b0000;
            ba_dst <= 4'b0000;
            ba_dok <= 4'b0000;
            ba_rdy <= 4'b0000;
            case (state_r)
                ST_IDLE: begin
                    if (ref_pend_r && refresh_en) begin
                        state_r <= ST_REF;
                        cnt_r   <= '0;
                    end else if (any_s) begin
                        state_r <= ST_WAIT;
                        bank_r  <= gidx_s;
                        ptr_r   <= gidx_s + 2'd1;
                        addr_r  <= addr_sel_s;
                        wr_r    <= (gidx_s == 2'd0) && ba_wr;
                        din_r   <= ba0_din;
                        mask_r  <= ba0_din_m;
                        cnt_r   <= '0;
                        wcnt_r  <= 2'd0;
                        ba_ack  <= grant_s;
                        if (gidx_s == 2'd0 && ba_wr && LAT == 1) ba_rdy <= 4'b0001;
                    end
                end
                ST_REF: begin
                    if (cnt_r == CW'(REF_CYCLES - 1)) state_r <= ST_IDLE;
                    else                              cnt_r   <= cnt_r + CW'(1);
                end
                ST_WAIT: begin
                    if (wr_r) begin
                        if (LAT == 1) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WDONE;
                            cnt_r   <= CW'(1);
                            ba_rdy  <= (LAT == 2) ? 4'b0001 : 4'b0000;
                        end
                    end else if (cnt_r == CW'(LAT - 1)) begin
                        state_r   <= ST_DATA;
                        wcnt_r    <= 2'd0;
                        ba_dok    <= bank_oh_s;
                        ba_dst    <= bank_oh_s;
                        ba_rdy    <= (BURST == 1) ? bank_oh_s : 4'b0000;
                        data_read <= rd_data_s;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (wcnt_r == 2'(BURST - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        wcnt_r    <= wcnt_r + 2'd1;
                        ba_dok    <= bank_oh_s;
                        ba_rdy    <= ((wcnt_r + 2'd1) == 2'(BURST - 1)) ? bank_oh_s : 4'b0000;
                        data_read <= rd_data_s;
                    end
                end
                ST_WDONE: begin
                    if (cnt_r == CW'(LAT - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r  <= cnt_r + CW'(1);
                        ba_rdy <= ((cnt_r + CW'(1)) == CW'(LAT - 1)) ? 4'b0001 : 4'b0000;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtsdram_bank_resp.sv
// Directed + randomized bench for jtsdram_bank_resp with a word-array reference model.
module tb_jtsdram_bank_resp;

    localparam int AW = 10;
    localparam int LAT = 3;
    localparam int BURST = 2;
    localparam int RP = 384;
    localparam int RC = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ba_rd;
    logic        ba_wr;
    logic [21:0] a0, a1, a2, a3;
    logic [15:0] din;
    logic [1:0]  dm;
    logic        ref_en;
    logic [3:0]  ack, dst, dok, rdy;
    logic [15:0] dread;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] mdl [0:(1<<AW)-1];

    always #5 clk = ~clk;

    jtsdram_bank_resp #(.AW(AW), .LAT(LAT), .BURST(BURST), .REF_PERIOD(RP), .REF_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .ba_rd(ba_rd), .ba_wr(ba_wr),
        .ba0_addr(a0), .ba1_addr(a1), .ba2_addr(a2), .ba3_addr(a3),
        .ba0_din(din), .ba0_din_m(dm), .refresh_en(ref_en),
        .ba_ack(ack), .ba_dst(dst), .ba_dok(dok), .ba_rdy(rdy), .data_read(dread)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // No output vector may ever have more than one bit set.
    always @(negedge clk) begin
        total++;
        assert ($countones(ack) <= 1 && $countones(dst) <= 1 && $countones(dok) <= 1 && $countones(rdy) <= 1)
        else begin
            bad++;
            $error("FAIL onehot observed=%h/%h/%h/%h expected=at most one bit", ack, dst, dok, rdy);
        end
    end

    // One request from raise to completion; expected ack delay counted from the raise cycle.
    task automatic txn(input bit wr, input int bank, input logic [AW-1:0] addr, input logic [15:0] wdata,
                       input logic [1:0] wmask, input int exp_wait, input logic [3:0] extra);
        logic [3:0]  oh;
        logic [15:0] ew;
        int w;
        int k;
        oh = 4'b0001 << bank;
        ew = 16'h0000;
        a0 = 22'($urandom); a1 = 22'($urandom); a2 = 22'($urandom); a3 = 22'($urandom);
        case (bank)
            0: a0[AW-1:0] = addr;
            1: a1[AW-1:0] = addr;
            2: a2[AW-1:0] = addr;
            default: a3[AW-1:0] = addr;
        endcase
        din = wr ? wdata : 16'($urandom);
        dm  = wr ? wmask : 2'($urandom);
        if (wr) begin
            ba_wr = 1'b1;
            ba_rd = extra | {3'b000, 1'($urandom)};
        end else begin
            ba_rd = oh | extra;
        end
        w = 0;
        do begin
            step();
            w++;
            if (ack == 4'b0000) begin
                chk("pre_ack_dok", dok, 4'b0000);
                chk("pre_ack_rdy", rdy, 4'b0000);
            end
        end while (ack == 4'b0000 && w < 64);
        ba_rd = 4'b0000;
        ba_wr = 1'b0;
        chk("ack_bank", ack, oh);
        chk("ack_wait", 32'(w), 32'(exp_wait));
        if (ack == 4'b0000) return;
        if (wr) begin
            for (int b = 0; b < 2; b++)
                if (!wmask[b]) mdl[addr][b*8 +: 8] = wdata[b*8 +: 8];
            for (int i = 1; i < LAT; i++) begin
                step();
                chk("wr_ack_pulse", ack, 4'b0000);
                chk("wr_dok", dok, 4'b0000);
                chk("wr_rdy", rdy, (i == LAT-1) ? 4'b0001 : 4'b0000);
            end
            step();
            chk("wr_end_rdy", rdy, 4'b0000);
        end else begin
            for (int i = 1; i < LAT + BURST; i++) begin
                step();
                chk("rd_ack_pulse", ack, 4'b0000);
                if (i < LAT) begin
                    chk("rd_lat_dok", dok, 4'b0000);
                    chk("rd_lat_rdy", rdy, 4'b0000);
                end else begin
                    k  = i - LAT;
                    ew = (bank == 0) ? mdl[(int'(addr) + k) % (1 << AW)] : 16'h0000;
                    chk("rd_dok", dok, oh);
                    chk("rd_dst", dst, (k == 0) ? oh : 4'b0000);
                    chk("rd_rdy", rdy, (k == BURST-1) ? oh : 4'b0000);
                    chk("rd_data", dread, ew);
                end
            end
            step();
            chk("rd_end_dok", dok, 4'b0000);
            chk("rd_hold", dread, ew);
        end
    endtask

    initial begin
        int ord [4];
        int at [4];
        int n;
        int t;
        int w;
        int bank;
        bit wr;
        logic [AW-1:0] addr;

        ba_rd = 4'b1111; ba_wr = 1'b0; ref_en = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0; din = '0; dm = '0;
        for (int i = 0; i < (1 << AW); i++) mdl[i] = 16'h0000;
        for (int i = 0; i < 4; i++) begin ord[i] = -1; at[i] = 0; end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 4'b0000);
        chk("rst_dst", dst, 4'b0000);
        chk("rst_dok", dok, 4'b0000);
        chk("rst_rdy", rdy, 4'b0000);
        chk("rst_data", dread, 16'h0000);

        // All four banks requesting from reset; each drops on its ack.
        rst_n = 1'b1;
        cyc = 0;
        n = 0;
        t = 0;
        while (n < 4 && t < 100) begin
            step();
            t++;
            if (ack != 4'b0000) begin
                for (int b = 0; b < 4; b++) if (ack[b]) ord[n] = b;
                at[n] = cyc;
                ba_rd = ba_rd & ~ack;
                n++;
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_first_ack", 32'(at[0]), 32'd1);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(ord[i]), 32'(i));
        for (int i = 1; i < 4; i++) chk("rr_gap", 32'(at[i] - at[i-1]), 32'(LAT + BURST + 1));
        repeat (LAT + BURST) step();

        txn(1'b1, 0, 10'h005, 16'hA55A, 2'b00, 1, 4'b0000);
        txn(1'b0, 0, 10'h005, 16'h0000, 2'b00, 1, 4'b0000);
        txn(1'b1, 0, 10'h005, 16'hFFFF, 2'b01, 1, 4'b0000);
        txn(1'b0, 0, 10'h005, 16'h0000, 2'b00, 1, 4'b0000);
        txn(1'b1, 0, 10'h3FF, 16'h1234, 2'b00, 1, 4'b0000);
        txn(1'b1, 0, 10'h000, 16'h5678, 2'b00, 1, 4'b0000);
        txn(1'b0, 0, 10'h3FF, 16'h0000, 2'b00, 1, 4'b0000);

        for (int r = 0; r < 24; r++) begin
            bank = $urandom_range(0, 3);
            wr   = (bank == 0) && ($urandom_range(0, 1) == 1);
            addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            txn(wr, bank, addr, 16'($urandom), 2'($urandom), 1, 4'b0000);
        end

        // Bank-2 read raised exactly when a refresh becomes pending.
        while ((cyc % RP) != RP - 1) step();
        ref_en = 1'b1;
        step();
        txn(1'b0, 2, AW'($urandom), 16'h0000, 2'b00, RC + 2, 4'b0000);
        ref_en = 1'b0;
        while ((cyc % RP) != RP - 1) step();
        step();
        txn(1'b0, 2, AW'($urandom), 16'h0000, 2'b00, 1, 4'b0000);

        // Reset during word 0 of a bank-0 burst, with banks 0/1/3 held through it.
        txn(1'b1, 0, 10'h02A, 16'hC3C3, 2'b00, 1, 4'b0000);
        a0 = {12'h000, 10'h02A};
        ba_rd = 4'b0001;
        w = 0;
        do begin step(); w++; end while (ack == 4'b0000 && w < 64);
        ba_rd = 4'b0000;
        chk("mid_ack", ack, 4'b0001);
        repeat (LAT) step();
        chk("mid_dok", dok, 4'b0001);
        chk("mid_data", dread, mdl[10'h02A]);
        #2;
        rst_n = 1'b0;
        ba_rd = 4'b1011;
        #1;
        chk("async_ack", ack, 4'b0000);
        chk("async_dst", dst, 4'b0000);
        chk("async_dok", dok, 4'b0000);
        chk("async_rdy", rdy, 4'b0000);
        chk("async_data", dread, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rst_rdy", rdy, 4'b0000);
            chk("hold_rst_ack", ack, 4'b0000);
        end
        rst_n = 1'b1;
        cyc = 0;
        txn(1'b0, 0, 10'h02A, 16'h0000, 2'b00, 1, 4'b1011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtsdram_bank_resp.md
# jtsdram_bank_resp

Synthesizable four-bank SDRAM responder: the memory-side counterpart of the bank request interface driven by `jtsdram_checker` and the game modules. It arbitrates the per-bank read requests and the bank-0 write request, serves them from small internal word arrays with configurable access latency and burst length, and inserts refresh windows. It is built as a fast simulation stand-in and FPGA loopback target, so checker and game logic can be exercised without the real SDRAM controller.

## Interface
- `AW`, 10: word-address bits stored per bank (2^AW x 16-bit words per bank)
- `LAT`, 3: cycles from ack to first data word; legal range 1..15
- `BURST`, 2: words returned per read; legal range 1..4
- `REF_PERIOD`, 384: cycles between refresh requests
- `REF_CYCLES`, 8: busy cycles per refresh

- `clk` in 1: single clock; all logic on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `ba_rd` in 4: per-bank read request, level, held until ack
- `ba_wr` in 1: bank-0 write request, level, held until ack
- `ba0_addr`, `ba1_addr`, `ba2_addr`, `ba3_addr` in 22 each: word address; only `[AW-1:0]` used
- `ba0_din` in 16: write data
- `ba0_din_m` in 2: byte mask; bit=1 suppresses that byte (`[1]` upper, `[0]` lower)
- `refresh_en` in 1: enables refresh insertion
- `ba_ack` out 4: one-cycle request accept pulse
- `ba_dst` out 4: one-cycle pulse with the first data word
- `ba_dok` out 4: high during every valid data word
- `ba_rdy` out 4: one-cycle pulse with the last read word, or write completion
- `data_read` out 16: read data; holds its last value otherwise

## Operation
- FSM states: IDLE, REF, WAIT, DATA, WDONE.
- Bank-0 request = `ba_rd[0] | ba_wr`. A write wins over a read on bank 0.
- **IDLE:**
  - Refresh pending and `refresh_en` -> REF. Refresh has priority over all requests.
  - Otherwise, any request -> grant one bank by round-robin. The search starts at `ptr`. On grant, `ptr` = granted bank + 1 (mod 4).
  - Latch bank, address, write flag, `ba0_din` and `ba0_din_m`. Go to WAIT; for a write, the next cycle goes to WDONE.
- **REF:** stay REF_CYCLES cycles, clear the pending flag, return to IDLE.
- **Refresh counter:**
  - Free-running, wraps at REF_PERIOD-1. On wrap it sets the pending flag.
  - The pending flag is cleared whenever `refresh_en`=0.
  - A wrap during a refresh is absorbed and does not queue a second refresh.
- **Read:**
  - WAIT counts LAT cycles, then DATA emits BURST words.
  - Word k reads `mem[bank][(addr+k) mod 2^AW]`; the address wraps within AW bits.
- **Write:**
  - The memory is updated in the ack cycle, honouring the byte mask.
  - WDONE counts LAT-1 cycles, then pulses `ba_rdy[0]`.
- Arrays are not touched by reset and power up at zero. Writes are possible only on bank 0; banks 1-3 always read zero.
- A request dropped before its ack is simply never granted. A request still high in IDLE after `ba_rdy` is treated as a new request.

## Timing
- **Reset:** every output is 0, including `data_read`. FSM goes to IDLE, `ptr`=0, refresh counter and pending flag=0. Reset takes effect immediately and asynchronously, including mid-burst; no partial pulses continue after release.
- **Read granted at IDLE cycle n:**
  - `ba_ack[g]` at n+1.
  - Word k at n+1+LAT+k, with `ba_dok[g]`=1 and `data_read` valid.
  - `ba_dst[g]` at n+1+LAT.
  - `ba_rdy[g]` at n+LAT+BURST.
  - IDLE again at n+1+LAT+BURST, where a new grant is possible.
- **Write granted at n:** `ba_ack[0]` and the memory update at n+1; `ba_rdy[0]` at n+LAT; IDLE at n+LAT+1.
- **Refresh entered at n:** IDLE at n+REF_CYCLES; requests are not acked before n+REF_CYCLES+1.
- At most one bit of each output vector is high in any cycle.

## Structure
- Shared package `jtsdram_pkg`: FSM state encoding, bank count 4, default LAT/BURST/refresh constants.
- Natural sub-module: `jtsdram_rr_arb`, a 4-way round-robin arbiter (req, ptr -> one-hot grant + index). The word arrays stay inline as one inferred RAM per bank.

## Test plan
- Write bank 0 addr 0x005, din 0xA55A, mask 00, then read bank 0 addr 0x005, defaults. Required: write ack at n+1, rdy at n+3; read returns 0xA55A then `mem[6]`; dst with word 0; rdy with word 1, 5 cycles after the read grant.
- Write 0xFFFF to addr 0x005 with mask 01, after the previous write. Required: read returns 0xFF5A.
- Assert `ba_rd`=1111 from reset, each dropped on its ack. Required: acks in order bank 0,1,2,3, spaced 6 cycles apart.
- Write addr 0x3FF = 0x1234 and addr 0x000 = 0x5678, then read from 0x3FF with BURST=2. Required: words 0x1234 then 0x5678.
- `refresh_en`=1, bank-2 read raised in the cycle the refresh becomes pending. Required: ack delayed until REF_CYCLES+1 cycles after REF entry. With `refresh_en`=0, no delay ever occurs.
- Assert `rst_n` low during word 0 of a burst. Required: all outputs 0 immediately, no `ba_rdy`. After release, a held request is re-acked starting from bank 0.
